fetch_pc_unit: RTL and testbench

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

---
 rtl/rv32i_types.sv | 19 +
 rtl/fetch_slot_mask.sv | 40 ++++
 rtl/fetch_pc_unit.sv | 213 +++++++++++++++++++++
 tb/tb_fetch_pc_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared fetch-side types and constants.
// Holds the fetch FSM state encoding, the instruction size in bytes, and a
// saturating counter helper used by the optional statistics counters.
package rv32i_types;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // 16-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : (val + 16'd1);
  endfunction

endpackage

// File: rtl/fetch_slot_mask.sv
// Combinational slot qualification for one fetch group.
// A slot is valid when its index is at or above the entry offset and no
// earlier valid slot was predicted taken. The first valid taken slot
// truncates the group and is reported so its target can become the next PC.
module fetch_slot_mask #(
  parameter  int FETCH_W = 2,
  localparam int CNT_W   = $clog2(FETCH_W) + 1,
  localparam int IDX_W   = (FETCH_W > 1) ? $clog2(FETCH_W) : 1
) (
  input  logic [CNT_W-1:0]   slot_off,
  input  logic [FETCH_W-1:0] pred_taken,
  output logic [FETCH_W-1:0] slot_mask,
  output logic [CNT_W-1:0]   slot_cnt,
  output logic               trunc_hit,
  output logic [IDX_W-1:0]   trunc_idx
);

  // Walk the slots in order, building the valid mask, count and truncation point.
  always_comb begin
    slot_mask = '0;
    slot_cnt  = '0;
    trunc_hit = 1'b0;
    trunc_idx = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      if ((CNT_W'(i) >= slot_off) && !trunc_hit) begin
        slot_mask[i] = 1'b1;
        slot_cnt     = slot_cnt + CNT_W'(1'b1);
        if (pred_taken[i]) begin
          trunc_hit = 1'b1;
          trunc_idx = IDX_W'(i);
        end else begin
          trunc_hit = 1'b0;
        end
      end else begin
        slot_mask[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: issues one aligned group request at a time, qualifies the
// returned slots, pushes them into the instruction queue with zero latency
// when space allows (otherwise parks them in HOLD), and handles commit
// redirects, including draining a response that is already in flight.
// Optional macro FETCH_PC_STATS_EN adds saturating flush/drop counters.
module fetch_pc_unit
  import rv32i_types::*;
#(
  parameter  int               WIDTH    = 32,
  parameter  int               FETCH_W  = 2,
  parameter  logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_0060),
  localparam int               CNT_W    = $clog2(FETCH_W) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       fetch_req,
  output logic [WIDTH-1:0]           fetch_addr,
  input  logic                       fetch_resp,
  input  logic [FETCH_W*WIDTH-1:0]   fetch_rdata,
  input  logic [FETCH_W-1:0]         pred_taken,
  input  logic [FETCH_W*WIDTH-1:0]   pred_tgt,
  input  logic [CNT_W-1:0]           iq_space,
  input  logic                       flush_valid,
  input  logic [WIDTH-1:0]           flush_pc,
  output logic                       enq,
  output logic [FETCH_W-1:0]         enq_mask,
  output logic [FETCH_W*WIDTH-1:0]   enq_data,
  output logic [WIDTH-1:0]           enq_pc,
`ifdef FETCH_PC_STATS_EN
  output logic [15:0]                stat_flush,
  output logic [15:0]                stat_drop,
`endif
  output logic [WIDTH-1:0]           pc_out
);

  localparam int IDX_W     = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
  localparam int GRP_BYTES = FETCH_W * INSTR_BYTES;

  fetch_state_t             state_q, state_d;
  logic [WIDTH-1:0]         pc_q, pc_d;
  logic                     ign_q, ign_d;
  logic [FETCH_W*WIDTH-1:0] hold_data_q, hold_data_d;
  logic [FETCH_W-1:0]       hold_mask_q, hold_mask_d;
  logic [CNT_W-1:0]         hold_cnt_q, hold_cnt_d;
  logic [WIDTH-1:0]         hold_npc_q, hold_npc_d;

  logic [CNT_W-1:0]         slot_off_s;
  logic [FETCH_W-1:0]       slot_mask_s;
  logic [CNT_W-1:0]         slot_cnt_s;
  logic                     trunc_hit_s;
  logic [IDX_W-1:0]         trunc_idx_s;
  logic [WIDTH-1:0]         base_s;
  logic [WIDTH-1:0]         grp_npc_s;
  logic [WIDTH-1:0]         lane_pc_s;
  logic                     fetch_req_s;
  logic                     enq_s;

  // Address arithmetic: entry slot, aligned group base and the group's next PC.
  // The sequential increment wraps naturally at 2^WIDTH.
  assign slot_off_s = CNT_W'((pc_q >> 2) & WIDTH'(FETCH_W - 1));
  assign base_s     = pc_q & ~WIDTH'(GRP_BYTES - 1);
  assign lane_pc_s  = {pc_q[WIDTH-1:2], 2'b00};
  assign grp_npc_s  = trunc_hit_s ? pred_tgt[trunc_idx_s*WIDTH +: WIDTH]
                                  : (base_s + WIDTH'(GRP_BYTES));

  fetch_slot_mask #(.FETCH_W(FETCH_W)) u_slot_mask (
    .slot_off   (slot_off_s),
    .pred_taken (pred_taken),
    .slot_mask  (slot_mask_s),
    .slot_cnt   (slot_cnt_s),
    .trunc_hit  (trunc_hit_s),
    .trunc_idx  (trunc_idx_s)
  );

  // Next-state, PC update, hold-buffer capture and queue push decode.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ign_d       = 1'b0;
    hold_data_d = hold_data_q;
    hold_mask_d = hold_mask_q;
    hold_cnt_d  = hold_cnt_q;
    hold_npc_d  = hold_npc_q;
    fetch_req_s = 1'b0;
    enq_s       = 1'b0;
    enq_mask    = '0;
    enq_data    = '0;
    enq_pc      = '0;
    case (state_q)
      FETCH: begin
        fetch_req_s = 1'b1;
        if (flush_valid) begin
          pc_d        = flush_pc;
          hold_mask_d = '0;
          // A response landing with the flush is the stale one; otherwise it is still to come.
          state_d     = fetch_resp ? FETCH : DRAIN;
        end else if (fetch_resp) begin
          if (ign_q) begin
            // Response belongs to a request issued before reset.
            state_d = FETCH;
          end else if (slot_cnt_s <= iq_space) begin
            enq_s    = 1'b1;
            enq_mask = slot_mask_s;
            enq_data = fetch_rdata;
            enq_pc   = lane_pc_s;
            pc_d     = grp_npc_s;
          end else begin
            hold_data_d = fetch_rdata;
            hold_mask_d = slot_mask_s;
            hold_cnt_d  = slot_cnt_s;
            hold_npc_d  = grp_npc_s;
            state_d     = HOLD;
          end
        end else begin
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (flush_valid) begin
          pc_d        = flush_pc;
          hold_mask_d = '0;
          state_d     = FETCH;
        end else if (hold_cnt_q <= iq_space) begin
          enq_s       = 1'b1;
          enq_mask    = hold_mask_q;
          enq_data    = hold_data_q;
          enq_pc      = lane_pc_s;
          pc_d        = hold_npc_q;
          hold_mask_d = '0;
          state_d     = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      DRAIN: begin
        if (flush_valid) begin
          pc_d = flush_pc;
          // The awaited stale response arriving with the new flush still ends the drain,
          // since no further response would ever come.
          state_d = fetch_resp ? FETCH : DRAIN;
        end else if (fetch_resp) begin
          state_d = FETCH;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Outputs are held quiet while reset is asserted.
  assign fetch_req  = fetch_req_s & rst;
  assign enq        = enq_s & rst;
  assign fetch_addr = base_s;
  assign pc_out     = pc_q;

  // State, PC and hold buffer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      ign_q       <= 1'b1;
      hold_data_q <= '0;
      hold_mask_q <= '0;
      hold_cnt_q  <= '0;
      hold_npc_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ign_q       <= ign_d;
      hold_data_q <= hold_data_d;
      hold_mask_q <= hold_mask_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_npc_q  <= hold_npc_d;
    end
  end

`ifdef FETCH_PC_STATS_EN
  logic        drop_evt_s;
  logic [15:0] stat_flush_q, stat_flush_d;
  logic [15:0] stat_drop_q, stat_drop_d;

  // Classify discarded groups and advance the saturating counters.
  always_comb begin
    drop_evt_s = 1'b0;
    case (state_q)
      FETCH:   drop_evt_s = fetch_resp && (flush_valid || ign_q);
      HOLD:    drop_evt_s = flush_valid;
      DRAIN:   drop_evt_s = fetch_resp;
      default: drop_evt_s = 1'b0;
    endcase
    stat_flush_d = flush_valid ? sat_inc16(stat_flush_q) : stat_flush_q;
    stat_drop_d  = drop_evt_s  ? sat_inc16(stat_drop_q)  : stat_drop_q;
  end

  // Statistics counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_flush_q <= 16'd0;
      stat_drop_q  <= 16'd0;
    end else begin
      stat_flush_q <= stat_flush_d;
      stat_drop_q  <= stat_drop_d;
    end
  end

  assign stat_flush = stat_flush_q;
  assign stat_drop  = stat_drop_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a FETCH_W=2 instance driven from a vector
// table plus hand-written HOLD/flush/drain sequences, and a FETCH_W=4 instance
// covering full-group wrap and mid-group entry.
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst;
  // FETCH_W = 2 instance
  logic        fetch_req, fetch_resp, flush_valid, enq;
  logic [31:0] fetch_addr, flush_pc, enq_pc, pc_out;
  logic [63:0] fetch_rdata, pred_tgt, enq_data;
  logic [1:0]  pred_taken, iq_space, enq_mask;
  // FETCH_W = 4 instance
  logic         fetch_req4, fetch_resp4, flush_valid4, enq4;
  logic [31:0]  fetch_addr4, flush_pc4, enq_pc4, pc_out4;
  logic [127:0] fetch_rdata4, pred_tgt4, enq_data4;
  logic [3:0]   pred_taken4, enq_mask4;
  logic [2:0]   iq_space4;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] start_pc;
    logic [1:0]  taken;
    logic [63:0] tgt;
    logic [1:0]  space;
    logic [63:0] rdata;
    logic [31:0] exp_addr;
    logic [1:0]  exp_mask;
    logic [31:0] exp_enq_pc;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [8];

  fetch_pc_unit #(.WIDTH(32), .FETCH_W(2), .RESET_PC(32'h0000_0060)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_resp(fetch_resp), .fetch_rdata(fetch_rdata), .pred_taken(pred_taken),
    .pred_tgt(pred_tgt), .iq_space(iq_space), .flush_valid(flush_valid),
    .flush_pc(flush_pc), .enq(enq), .enq_mask(enq_mask), .enq_data(enq_data),
    .enq_pc(enq_pc), .pc_out(pc_out)
  );

  fetch_pc_unit #(.WIDTH(32), .FETCH_W(4), .RESET_PC(32'h0000_0060)) dut4 (
    .clk(clk), .rst(rst), .fetch_req(fetch_req4), .fetch_addr(fetch_addr4),
    .fetch_resp(fetch_resp4), .fetch_rdata(fetch_rdata4), .pred_taken(pred_taken4),
    .pred_tgt(pred_tgt4), .iq_space(iq_space4), .flush_valid(flush_valid4),
    .flush_pc(flush_pc4), .enq(enq4), .enq_mask(enq_mask4), .enq_data(enq_data4),
    .enq_pc(enq_pc4), .pc_out(pc_out4)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Force the W=2 PC: a flush together with a (discarded) response keeps FETCH.
  task automatic set_pc(input logic [31:0] pc);
    flush_valid = 1'b1; flush_pc = pc; fetch_resp = 1'b1;
    #1;
    chk("setpc_enq", enq, 1'b0);
    step();
    flush_valid = 1'b0; fetch_resp = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    fetch_resp = 1'b0; fetch_rdata = '0; pred_taken = '0; pred_tgt = '0;
    iq_space = 2'd0; flush_valid = 1'b0; flush_pc = '0;
    fetch_resp4 = 1'b0; fetch_rdata4 = '0; pred_taken4 = '0; pred_tgt4 = '0;
    iq_space4 = 3'd0; flush_valid4 = 1'b0; flush_pc4 = '0;

    //            start          tk     tgt {s1,s0}                        sp     rdata                    addr           mask   enq_pc         next pc
    vecs[0] = '{32'h0000_0060, 2'b00, 64'h0,                           2'd2, 64'hAAAA_0001_BBBB_0002, 32'h0000_0060, 2'b11, 32'h0000_0060, 32'h0000_0068};
    vecs[1] = '{32'h0000_0064, 2'b00, 64'h0,                           2'd2, 64'h1234_5678_9ABC_DEF0, 32'h0000_0060, 2'b10, 32'h0000_0064, 32'h0000_0068};
    vecs[2] = '{32'h0000_0060, 2'b01, 64'h0000_0000_0000_0200,         2'd2, 64'h0F0F_0F0F_F0F0_F0F0, 32'h0000_0060, 2'b01, 32'h0000_0060, 32'h0000_0200};
    vecs[3] = '{32'h0000_0060, 2'b10, 64'h0000_0300_0000_0000,         2'd3, 64'h5555_5555_AAAA_AAAA, 32'h0000_0060, 2'b11, 32'h0000_0060, 32'h0000_0300};
    vecs[4] = '{32'h0000_0064, 2'b01, 64'h0000_0000_0000_0200,         2'd2, 64'hDEAD_BEEF_CAFE_F00D, 32'h0000_0060, 2'b10, 32'h0000_0064, 32'h0000_0068};
    vecs[5] = '{32'h0000_006C, 2'b10, 64'h0000_0080_0000_0000,         2'd1, 64'h0000_1111_2222_3333, 32'h0000_0068, 2'b10, 32'h0000_006C, 32'h0000_0080};
    vecs[6] = '{32'hFFFF_FFF8, 2'b00, 64'h0,                           2'd2, 64'h7777_8888_9999_AAAA, 32'hFFFF_FFF8, 2'b11, 32'hFFFF_FFF8, 32'h0000_0000};
    vecs[7] = '{32'hFFFF_FFFC, 2'b11, 64'h0000_0010_0000_0020,         2'd1, 64'h4444_3333_2222_1111, 32'hFFFF_FFF8, 2'b10, 32'hFFFF_FFFC, 32'h0000_0010};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fetch_req", fetch_req, 1'b0);
    chk("rst_enq", enq, 1'b0);
    chk("rst_pc", pc_out, 32'h0000_0060);
    chk("rst_fetch_req4", fetch_req4, 1'b0);
    rst = 1'b1;
    #1;
    chk("post_rst_req", fetch_req, 1'b1);
    chk("post_rst_addr", fetch_addr, 32'h0000_0060);

    // Stale response on the first post-reset cycle is not enqueued
    fetch_resp = 1'b1; iq_space = 2'd2; fetch_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    #1;
    chk("stale_enq", enq, 1'b0);
    step();
    fetch_resp = 1'b0;
    chk("stale_pc", pc_out, 32'h0000_0060);

    // First real group after reset
    fetch_resp = 1'b1; pred_taken = 2'b00; iq_space = 2'd2; fetch_rdata = 64'h0000_0002_0000_0001;
    #1;
    chk("first_enq", enq, 1'b1);
    chk("first_mask", enq_mask, 2'b11);
    chk("first_enq_pc", enq_pc, 32'h0000_0060);
    chk("first_data", enq_data, 64'h0000_0002_0000_0001);
    step();
    fetch_resp = 1'b0;
    chk("first_pc", pc_out, 32'h0000_0068);

    // Table-driven groups
    for (int i = 0; i < 8; i++) begin
      set_pc(vecs[i].start_pc);
      chk("vec_req", fetch_req, 1'b1);
      chk("vec_addr", fetch_addr, vecs[i].exp_addr);
      fetch_resp = 1'b1; pred_taken = vecs[i].taken; pred_tgt = vecs[i].tgt;
      iq_space = vecs[i].space; fetch_rdata = vecs[i].rdata;
      #1;
      chk("vec_enq", enq, 1'b1);
      chk("vec_mask", enq_mask, vecs[i].exp_mask);
      chk("vec_enq_pc", enq_pc, vecs[i].exp_enq_pc);
      chk("vec_data", enq_data, vecs[i].rdata);
      step();
      fetch_resp = 1'b0; pred_taken = 2'b00; pred_tgt = '0;
      chk("vec_next_pc", pc_out, vecs[i].exp_pc);
    end

    // HOLD: no room for three cycles, room on the fourth
    set_pc(32'h0000_0060);
    fetch_resp = 1'b1; iq_space = 2'd1; fetch_rdata = 64'hC0DE_0002_C0DE_0001;
    #1;
    chk("hold_c1_enq", enq, 1'b0);
    step();
    fetch_resp = 1'b0; fetch_rdata = '0;
    chk("hold_req", fetch_req, 1'b0);
    chk("hold_pc", pc_out, 32'h0000_0060);
    chk("hold_c2_enq", enq, 1'b0);
    step();
    chk("hold_c3_enq", enq, 1'b0);
    step();
    iq_space = 2'd2;
    #1;
    chk("hold_c4_enq", enq, 1'b1);
    chk("hold_c4_mask", enq_mask, 2'b11);
    chk("hold_c4_enq_pc", enq_pc, 32'h0000_0060);
    chk("hold_c4_data", enq_data, 64'hC0DE_0002_C0DE_0001);
    step();
    chk("hold_exit_req", fetch_req, 1'b1);
    chk("hold_exit_pc", pc_out, 32'h0000_0068);

    // Flush while in HOLD discards the parked group and returns to FETCH
    fetch_resp = 1'b1; iq_space = 2'd1;
    step();
    fetch_resp = 1'b0;
    chk("hold2_req", fetch_req, 1'b0);
    flush_valid = 1'b1; flush_pc = 32'h0000_0500; iq_space = 2'd2;
    #1;
    chk("hold_flush_enq", enq, 1'b0);
    step();
    flush_valid = 1'b0;
    chk("hold_flush_req", fetch_req, 1'b1);
    chk("hold_flush_pc", pc_out, 32'h0000_0500);
    fetch_resp = 1'b1; fetch_rdata = 64'h0000_0502_0000_0501;
    #1;
    chk("after_hold_flush_enq_pc", enq_pc, 32'h0000_0500);
    chk("after_hold_flush_data", enq_data, 64'h0000_0502_0000_0501);
    step();
    fetch_resp = 1'b0;
    chk("after_hold_flush_pc", pc_out, 32'h0000_0508);

    // Flush with a request outstanding: drain the stale response
    flush_valid = 1'b1; flush_pc = 32'h0000_0400;
    #1;
    chk("drain_flush_enq", enq, 1'b0);
    step();
    flush_valid = 1'b0;
    chk("drain_pc", pc_out, 32'h0000_0400);
    chk("drain_req", fetch_req, 1'b0);
    fetch_resp = 1'b1; fetch_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    #1;
    chk("drain_resp_enq", enq, 1'b0);
    step();
    fetch_resp = 1'b0;
    chk("drain_exit_req", fetch_req, 1'b1);
    chk("drain_exit_addr", fetch_addr, 32'h0000_0400);
    fetch_resp = 1'b1; fetch_rdata = 64'h0000_0404_0000_0400;
    #1;
    chk("redir_enq", enq, 1'b1);
    chk("redir_mask", enq_mask, 2'b11);
    chk("redir_enq_pc", enq_pc, 32'h0000_0400);
    step();
    fetch_resp = 1'b0;
    chk("redir_pc", pc_out, 32'h0000_0408);

    // Second flush while draining updates the PC and keeps draining
    flush_valid = 1'b1; flush_pc = 32'h0000_0600;
    step();
    flush_pc = 32'h0000_0704;
    step();
    flush_valid = 1'b0;
    chk("drain2_pc", pc_out, 32'h0000_0704);
    chk("drain2_req", fetch_req, 1'b0);
    fetch_resp = 1'b1;
    #1;
    chk("drain2_resp_enq", enq, 1'b0);
    step();
    fetch_resp = 1'b0;
    chk("drain2_exit_addr", fetch_addr, 32'h0000_0700);
    fetch_resp = 1'b1;
    #1;
    chk("drain2_mask", enq_mask, 2'b10);
    chk("drain2_enq_pc", enq_pc, 32'h0000_0704);
    step();
    fetch_resp = 1'b0;
    chk("drain2_pc_next", pc_out, 32'h0000_0708);

    // FETCH_W = 4: full group at the top of the address space wraps to zero
    flush_valid4 = 1'b1; flush_pc4 = 32'hFFFF_FFF0; fetch_resp4 = 1'b1;
    step();
    flush_valid4 = 1'b0; fetch_resp4 = 1'b0;
    chk("w4_addr", fetch_addr4, 32'hFFFF_FFF0);
    fetch_resp4 = 1'b1; pred_taken4 = 4'b0000; iq_space4 = 3'd4;
    fetch_rdata4 = 128'h0000_0004_0000_0003_0000_0002_0000_0001;
    #1;
    chk("w4_enq", enq4, 1'b1);
    chk("w4_mask", enq_mask4, 4'hF);
    chk("w4_enq_pc", enq_pc4, 32'hFFFF_FFF0);
    step();
    fetch_resp4 = 1'b0;
    chk("w4_wrap_pc", pc_out4, 32'h0000_0000);

    // FETCH_W = 4: taken in slot 2 truncates the group
    fetch_resp4 = 1'b1; pred_taken4 = 4'b0100; pred_tgt4 = 128'h0;
    pred_tgt4[95:64] = 32'h0000_0040;
    #1;
    chk("w4_tk_mask", enq_mask4, 4'b0111);
    step();
    fetch_resp4 = 1'b0; pred_taken4 = 4'b0000;
    chk("w4_tk_pc", pc_out4, 32'h0000_0040);

    // FETCH_W = 4: mid-group entry, count equal to space
    flush_valid4 = 1'b1; flush_pc4 = 32'h0000_0048; fetch_resp4 = 1'b1;
    step();
    flush_valid4 = 1'b0;
    iq_space4 = 3'd2;
    #1;
    chk("w4_mid_enq", enq4, 1'b1);
    chk("w4_mid_mask", enq_mask4, 4'b1100);
    chk("w4_mid_enq_pc", enq_pc4, 32'h0000_0048);
    step();
    fetch_resp4 = 1'b0;
    chk("w4_mid_pc", pc_out4, 32'h0000_0050);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
